// File: rtl/adder_share_pkg.sv
// Shared defaults, round-robin pick result type and the round-robin search helper
// used by the adder-sharing arbiter.
package adder_share_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned MAX_IDW  = 3;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [MAX_IDW-1:0]  ptr,
                                       input int unsigned         nreq);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      pos = (32'(ptr) + k) % nreq;
      if (k < nreq && !res.found && valid[pos[MAX_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// Plain n-bit ripple-carry adder: sum = a + b + cin, carry out of the top bit.
module adder_share_arbiter_adder #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         cin_i,
  output logic [n-1:0] sum_o,
  output logic         cout_o
);

  logic [n:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int unsigned i = 0; i < n; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[n];
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one ripple adder among NREQ requesters, with a one-entry
// registered response slot tagged by requester ID.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic [IDW-1:0]    rsp_id
);

  logic               rsp_valid_q, rsp_valid_d;
  logic [N-1:0]       rsp_sum_q,   rsp_sum_d;
  logic               rsp_cout_q,  rsp_cout_d;
  logic               rsp_ovf_q,   rsp_ovf_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;

  logic [MAX_NREQ-1:0] valid_ext;
  logic [MAX_IDW-1:0]  ptr_ext;
  rr_pick_t            pick;
  logic                slot_free;
  logic                grant;
  logic [N-1:0]        a_sel, b_sel, add_sum;
  logic                cin_sel, add_cout, add_ovf;

  // Grant is gated by rst_n so req_ready is low throughout reset, not just after an edge.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NREQ-1:0]      = req_valid;
    ptr_ext                  = '0;
    ptr_ext[IDW-1:0]         = rr_ptr_q;
    pick                     = rr_pick(valid_ext, ptr_ext, NREQ);
    slot_free                = !rsp_valid_q || rsp_ready;
    grant                    = rst_n && slot_free && pick.found;
    req_ready                = '0;
    a_sel                    = '0;
    b_sel                    = '0;
    cin_sel                  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == MAX_IDW'(i)) begin
        req_ready[i] = grant;
        a_sel        = req_a[i*N +: N];
        b_sel        = req_b[i*N +: N];
        cin_sel      = req_cin[i];
      end
    end
  end

  adder_share_arbiter_adder #(
    .n(N)
  ) u_adder (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .cin_i (cin_sel),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  assign add_ovf = (a_sel[N-1] == b_sel[N-1]) && (add_sum[N-1] != a_sel[N-1]);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_ovf_d   = add_ovf;
      rsp_id_d    = IDW'(pick.idx);
      rr_ptr_d    = IDW'((32'(pick.idx) + 1) % NREQ);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter against a behavioural round-robin/adder model.
module tb_adder_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_cin;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [N-1:0]      rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [N+IDW+2:0]  rsp_act;

  always #5 clk = ~clk;

  adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
  );

  assign rsp_act = {rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id};

  int errors = 0;
  int checks = 0;

  logic [N-1:0] a_arr [NREQ];
  logic [N-1:0] b_arr [NREQ];
  logic         cin_arr [NREQ];

  int           m_ptr;
  bit           m_valid;
  logic [N-1:0] m_sum;
  bit           m_cout, m_ovf;
  int           m_id;

  typedef struct {
    int           id;
    logic [N-1:0] sum;
    bit           cout;
    bit           ovf;
  } res_t;
  res_t sb_q[$];

  function automatic void ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                  output logic [N-1:0] s, output bit co, output bit ov);
    logic [N:0] full;
    longint     ss;
    full = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    s    = full[N-1:0];
    co   = full[N];
    ss   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    ov   = (ss > SMAX) || (ss < SMIN);
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Round-robin rule: first valid requester scanning from the pointer, only when the slot can take it.
  function automatic int model_grant();
    int idx;
    if (rst_n !== 1'b1) return -1;
    if (m_valid && rsp_ready !== 1'b1) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [N+IDW+2:0] exp_rsp();
    return {m_valid, m_sum, m_cout, m_ovf, IDW'(m_id)};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_id = 0;
    sb_q.delete();
  endtask

  task automatic settle(output int g);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = a_arr[i];
      req_b[i*N +: N] = b_arr[i];
      req_cin[i]      = cin_arr[i];
    end
    #1;
    g = model_grant();
  endtask

  task automatic commit(input int g);
    if (g >= 0) begin
      ref_add(a_arr[g], b_arr[g], cin_arr[g], m_sum, m_cout, m_ovf);
      m_valid = 1;
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000);
    end
    checks++;
    if (rsp_act !== exp_rsp()) begin
      errors++; $display("FAIL reset_rsp: got %h expected %h", rsp_act, exp_rsp());
    end
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int g;
    a_arr[0] = 32'd5; b_arr[0] = 32'd7; cin_arr[0] = 1'b0;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    settle(g);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0001);
    end
    commit(g);
    checks++;
    if (rsp_act !== {1'b1, 32'd12, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL single_rsp: got %h expected %h", rsp_act, {1'b1, 32'd12, 1'b0, 1'b0, 2'd0});
    end
    req_valid = '1;
    settle(g);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL single_ptr_next: got %b expected %b", req_ready, 4'b0010);
    end
    commit(g);
    checks++;
    if (rsp_act !== exp_rsp()) begin
      errors++; $display("FAIL single_second_rsp: got %h expected %h", rsp_act, exp_rsp());
    end
    if (g >= 0) begin a_arr[g] = rand_op(); b_arr[g] = rand_op(); cin_arr[g] = 1'($urandom); end
  endtask

  task automatic test_round_robin();
    int g;
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle(g);
      checks++;
      if (req_ready !== onehot(g) || $countones(req_ready) != 1) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, onehot(g));
      end
      commit(g);
      checks++;
      if (rsp_act !== exp_rsp()) begin
        errors++; $display("FAIL rr_rsp[%0d]: got %h expected %h", c, rsp_act, exp_rsp());
      end
      if (g >= 0) begin a_arr[g] = rand_op(); b_arr[g] = rand_op(); cin_arr[g] = 1'($urandom); end
    end
  endtask

  task automatic test_arith();
    int g;
    logic [N+N+N+3-1:0] tbl [4];
    logic [N+N+N+3-1:0] row;
    logic [N-1:0] e_sum;
    logic e_cout, e_ovf;
    // a, b, cin, sum, cout, ovf
    tbl[0] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[3] = {32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    req_valid = 4'b0010; rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      row = tbl[t];
      a_arr[1] = row[3*N+2 -: N]; b_arr[1] = row[2*N+2 -: N]; cin_arr[1] = row[N+2];
      e_sum = row[N+1 -: N]; e_cout = row[1]; e_ovf = row[0];
      settle(g);
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++; $display("FAIL arith_ready[%0d]: got %b expected %b", t, req_ready, 4'b0010);
      end
      commit(g);
      checks++;
      if (rsp_act !== {1'b1, e_sum, e_cout, e_ovf, 2'd1}) begin
        errors++; $display("FAIL arith_rsp[%0d]: got %h expected %h", t, rsp_act, {1'b1, e_sum, e_cout, e_ovf, 2'd1});
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [N+IDW+2:0] held;
    held = rsp_act;
    a_arr[2] = rand_op(); b_arr[2] = rand_op(); cin_arr[2] = 1'($urandom);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle(g);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, req_ready, 4'b0000);
      end
      commit(g);
      checks++;
      if (rsp_act !== exp_rsp() || rsp_act !== held) begin
        errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", c, rsp_act, exp_rsp());
      end
    end
    rsp_ready = 1'b1;
    settle(g);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release_ready: got %b expected %b", req_ready, 4'b0100);
    end
    commit(g);
    checks++;
    if (rsp_act !== exp_rsp() || rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL bp_release_rsp: got %h expected %h", rsp_act, exp_rsp());
    end
    req_valid = '0;
    settle(g);
    commit(g);
    checks++;
    if (rsp_act !== exp_rsp()) begin
      errors++; $display("FAIL drain_hold: got %h expected %h", rsp_act, exp_rsp());
    end
  endtask

  task automatic test_reset_midstream();
    int g;
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle(g);
      commit(g);
      if (g >= 0) begin a_arr[g] = rand_op(); b_arr[g] = rand_op(); end
    end
    settle(g);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL midreset_immediate: got valid=%b ready=%b expected valid=0 ready=0", rsp_valid, req_ready);
    end
    checks++;
    if (rsp_act !== exp_rsp()) begin
      errors++; $display("FAIL midreset_clear: got %h expected %h", rsp_act, exp_rsp());
    end
    @(negedge clk) rst_n = 1'b1;
    settle(g);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_first: got %b expected %b", req_ready, 4'b0001);
    end
    commit(g);
    checks++;
    if (rsp_act !== exp_rsp()) begin
      errors++; $display("FAIL midreset_rsp: got %h expected %h", rsp_act, exp_rsp());
    end
    req_valid = '0;
    settle(g);
    commit(g);
  endtask

  task automatic test_random();
    int   g;
    bit   pend [NREQ];
    int   waited [NREQ];
    res_t r, e;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; waited[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; waited[i] = 0;
          a_arr[i] = rand_op(); b_arr[i] = rand_op(); cin_arr[i] = 1'($urandom);
        end
        req_valid[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle(g);
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, onehot(g));
      end
      if (m_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rand_sb_empty[%0d]: got response with no expected entry", c);
        end else begin
          e = sb_q.pop_front();
          if (rsp_valid !== 1'b1 || rsp_sum !== e.sum || rsp_cout !== e.cout || rsp_ovf !== e.ovf || rsp_id !== IDW'(e.id)) begin
            errors++;
            $display("FAIL rand_sb[%0d]: got v=%b id=%0d sum=%h c=%b o=%b expected v=1 id=%0d sum=%h c=%b o=%b",
                     c, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, e.id, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (g >= 0) begin
        checks++;
        if (waited[g] >= NREQ) begin
          errors++; $display("FAIL rand_starve[%0d]: got %0d grants waited expected < %0d", c, waited[g], NREQ);
        end
        for (int i = 0; i < NREQ; i++) if (pend[i] && i != g) waited[i]++;
        r.id = g;
        ref_add(a_arr[g], b_arr[g], cin_arr[g], r.sum, r.cout, r.ovf);
        sb_q.push_back(r);
      end
      commit(g);
      if (g >= 0) pend[g] = 0;
      checks++;
      if (rsp_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, rsp_valid, m_valid);
      end
    end
    checks++;
    if (sb_q.size() != (m_valid ? 1 : 0)) begin
      errors++; $display("FAIL rand_sb_final: got %0d outstanding expected %0d", sb_q.size(), m_valid ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = rand_op(); b_arr[i] = rand_op(); cin_arr[i] = 1'($urandom);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_arith();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
